univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: ports clk and rst_n.
REQ-002 Parameter WIDTH SHALL default to 8 and sets the register width; legal range is 2..64.
REQ-003 Parameter RESET_VAL SHALL default to 0 and sets the q value loaded on reset, WIDTH bits.
REQ-004 Port clk SHALL be an input, 1 bit wide: rising-edge clock for all state.
REQ-005 Port rst_n SHALL be an input, 1 bit wide: asynchronous active-low reset.
REQ-006 Port en SHALL be an input, 1 bit wide: operation enable; low means hold.
REQ-007 Port mode SHALL be an input, 2 bits wide: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
REQ-008 Port d SHALL be an input, WIDTH bits wide: parallel load data.
REQ-009 Port sin_r SHALL be an input, 1 bit wide: serial bit entering q[0] on shift left.
REQ-010 Port sin_l SHALL be an input, 1 bit wide: serial bit entering q[WIDTH-1] on shift right.
REQ-011 Port rot SHALL be an input, 1 bit wide: rotate select, used only when the macro is enabled (see Configuration).
REQ-012 Port q SHALL be an output, WIDTH bits wide: register contents.
REQ-013 Port sout_l SHALL be an output, 1 bit wide: equals q[WIDTH-1], combinational from q.
REQ-014 Port sout_r SHALL be an output, 1 bit wide: equals q[0], combinational from q.
REQ-015 Port shcnt SHALL be an output, clog2(WIDTH+1) bits wide: count of shifts since the last load or reset.
REQ-016 Port done SHALL be an output, 1 bit wide: high while shcnt == WIDTH.

Function
REQ-017 All state SHALL update only on the rising edge of clk, with one-cycle latency from inputs to q and shcnt.
REQ-018 With en=0 or mode=00, q and shcnt SHALL hold their values.
REQ-019 With en=1 and mode=01, q SHALL become {q[WIDTH-2:0], sin_r}.
REQ-020 With en=1 and mode=10, q SHALL become {sin_l, q[WIDTH-1:1]}.
REQ-021 With en=1 and mode=11, q SHALL become d and shcnt SHALL become 0.
REQ-022 Each enabled shift (mode 01 or 10) SHALL increment shcnt by 1; shcnt SHALL saturate at WIDTH and never wrap.
REQ-023 Shifts SHALL keep updating q once shcnt is saturated; only the counter stops.
REQ-024 A change of shift direction SHALL NOT clear shcnt; both directions count.
REQ-025 done SHALL be combinational from shcnt and SHALL deassert on the cycle after a load.
REQ-026 An X or Z on mode while en=1 is a bench error; the RTL SHALL treat an undecoded mode as hold.

Reset
REQ-027 rst_n low SHALL immediately set q=RESET_VAL, shcnt=0 and done=0, independent of clk.
REQ-028 Reset asserted mid-shift SHALL abandon the operation; no partial state SHALL survive.
REQ-029 After rst_n deasserts, the first operation SHALL take effect on the first rising edge at which rst_n is high.

Configuration
REQ-030 Macro SHIFT_ROTATE_EN SHALL gate rotate support.
REQ-031 With SHIFT_ROTATE_EN defined and rot=1, shift left SHALL insert q[WIDTH-1] in place of sin_r, and shift right SHALL insert q[0] in place of sin_l; shcnt counting is unchanged.
REQ-032 With SHIFT_ROTATE_EN undefined, the rot port SHALL still exist but be ignored, and behaviour SHALL equal rot=0.

Verification (WIDTH=8, RESET_VAL=0)
REQ-033 Assert rst_n=0 between clock edges with q=8'hFF -> q=8'h00 and shcnt=0 before the next edge.
REQ-034 Load d=8'hA5, then 8 shift-left cycles with sin_r=0 -> sout_l sequence 1,0,1,0,0,1,0,1; q=8'h00; shcnt=8; done=1.
REQ-035 From q=8'h81, shift right with sin_l=1 -> q=8'hC0 and shcnt=1; en=0 for 3 cycles -> q and shcnt unchanged.
REQ-036 Issue 10 consecutive shifts -> shcnt saturates at 8, done stays high, q keeps shifting; then a load -> shcnt=0 and done=0 on the next cycle.
REQ-037 SHIFT_ROTATE_EN defined, load 8'h96, rot=1, 8 shift lefts -> q=8'h96 after 8 shifts and done=1; same test with the macro undefined -> q=8'h00 when sin_r=0.
REQ-038 Assert reset mid-sequence after 4 shifts -> q=8'h00 and shcnt=0; the next load works normally.

Source files
------------

// File: rtl/univ_shift_reg.sv
// ============================================================================
// Module   : univ_shift_reg
// Brief    : Universal shift register (hold / shift left / shift right / load)
//            with a saturating shift counter. Optional rotate support is
//            compiled in when the macro SHIFT_ROTATE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_reg #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [1:0]                     mode,
    input  logic [WIDTH-1:0]               d,
    input  logic                           sin_r,
    input  logic                           sin_l,
    input  logic                           rot,
    output logic [WIDTH-1:0]               q,
    output logic                           sout_l,
    output logic                           sout_r,
    output logic [$clog2(WIDTH+1)-1:0]     shcnt,
    output logic                           done
);

    localparam int                   CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]     C_CNT_MAX = CNT_W'(WIDTH);

    localparam logic [1:0] C_MODE_HOLD = 2'b00;
    localparam logic [1:0] C_MODE_SHL  = 2'b01;
    localparam logic [1:0] C_MODE_SHR  = 2'b10;
    localparam logic [1:0] C_MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] q_q,     q_d;
    logic [CNT_W-1:0] shcnt_q, shcnt_d;
    logic             w_ins_lsb;
    logic             w_ins_msb;
    logic [CNT_W-1:0] w_cnt_inc;

`ifdef SHIFT_ROTATE_EN
    assign w_ins_lsb = rot ? q_q[WIDTH-1] : sin_r;
    assign w_ins_msb = rot ? q_q[0]       : sin_l;
`else
    // rot exists on the port list for pin compatibility but has no effect here.
    logic w_unused_rot;
    assign w_unused_rot = rot;
    assign w_ins_lsb    = sin_r;
    assign w_ins_msb    = sin_l;
`endif

    assign w_cnt_inc = (shcnt_q == C_CNT_MAX) ? shcnt_q : shcnt_q + CNT_W'(1);

    always_comb begin
        q_d     = q_q;
        shcnt_d = shcnt_q;
        if (en) begin
            case (mode)
                C_MODE_SHL: begin
                    q_d     = {q_q[WIDTH-2:0], w_ins_lsb};
                    shcnt_d = w_cnt_inc;
                end
                C_MODE_SHR: begin
                    q_d     = {w_ins_msb, q_q[WIDTH-1:1]};
                    shcnt_d = w_cnt_inc;
                end
                C_MODE_LOAD: begin
                    q_d     = d;
                    shcnt_d = '0;
                end
                C_MODE_HOLD: begin
                    q_d     = q_q;
                    shcnt_d = shcnt_q;
                end
                // Undecodable (X/Z) mode values fall through to hold.
                default: begin
                    q_d     = q_q;
                    shcnt_d = shcnt_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= RESET_VAL;
            shcnt_q <= '0;
        end else begin
            q_q     <= q_d;
            shcnt_q <= shcnt_d;
        end
    end

    assign q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign shcnt  = shcnt_q;
    assign done   = (shcnt_q == C_CNT_MAX);

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// ============================================================================
// Module   : tb_univ_shift_reg
// Brief    : Directed self-checking bench for univ_shift_reg (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_univ_shift_reg;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] d;
    logic       sin_r;
    logic       sin_l;
    logic       rot;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic [3:0] shcnt;
    logic       done;

    int n_vec;
    int n_miscmp;

    univ_shift_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .mode   (mode),
        .d      (d),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .rot    (rot),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .shcnt  (shcnt),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miscmp++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, then sample 1 ns after the next rising edge.
    task automatic step(input logic e, input logic [1:0] m, input logic [7:0] dd,
                        input logic sr, input logic sl, input logic rt);
        @(negedge clk);
        en    = e;
        mode  = m;
        d     = dd;
        sin_r = sr;
        sin_l = sl;
        rot   = rt;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] pat;
    logic [7:0] rot_exp;
    logic [7:0] rot_mid;

    initial begin
        n_vec    = 0;
        n_miscmp = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        mode     = 2'b00;
        d        = 8'h00;
        sin_r    = 1'b0;
        sin_l    = 1'b0;
        rot      = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q",     q,      8'h00);
        chk("rst_shcnt", shcnt,  4'd0);
        chk("rst_done",  done,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset release performs the load
        step(1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0);
        chk("load_ff_q", q, 8'hFF);
        chk("load_ff_sout_r", sout_r, 1'b1);

        // Asynchronous reset between edges
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_q",     q,     8'h00);
        chk("async_rst_shcnt", shcnt, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load A5 then shift out MSB-first
        step(1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("load_a5_q", q, 8'hA5);
        pat = 8'b1010_0101;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("sout_l_%0d", i), sout_l, pat[7-i]);
            if (i == 7) chk("done_at_7", done, 1'b0);
            step(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        chk("shl8_q",     q,     8'h00);
        chk("shl8_shcnt", shcnt, 4'd8);
        chk("shl8_done",  done,  1'b1);

        // Shift right from 81, then enable low holds
        step(1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("shr_q",     q,     8'hC0);
        chk("shr_shcnt", shcnt, 4'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b01, 8'hFF, 1'b1, 1'b1, 1'b0);
            chk($sformatf("hold_en_q_%0d", i),     q,     8'hC0);
            chk($sformatf("hold_en_shcnt_%0d", i), shcnt, 4'd1);
        end
        step(1'b1, 2'b00, 8'hFF, 1'b1, 1'b1, 1'b0);
        chk("hold_mode_q",     q,     8'hC0);
        chk("hold_mode_shcnt", shcnt, 4'd1);

        // Ten shifts: counter saturates while data keeps moving
        step(1'b1, 2'b11, 8'h01, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("sat8_q",     q,     8'h00);
        chk("sat8_shcnt", shcnt, 4'd8);
        step(1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("sat9_q",     q,     8'h80);
        chk("sat9_shcnt", shcnt, 4'd8);
        step(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("sat10_q",     q,     8'h40);
        chk("sat10_shcnt", shcnt, 4'd8);
        chk("sat10_done",  done,  1'b1);
        step(1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("reload_q",     q,     8'h3C);
        chk("reload_shcnt", shcnt, 4'd0);
        chk("reload_done",  done,  1'b0);

        // Rotate request: honoured only when the rotate build is selected
`ifdef SHIFT_ROTATE_EN
        rot_mid = 8'h69;
        rot_exp = 8'h96;
`else
        rot_mid = 8'h60;
        rot_exp = 8'h00;
`endif
        step(1'b1, 2'b11, 8'h96, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rot4_q", q, rot_mid);
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rot8_q",    q,    rot_exp);
        chk("rot8_done", done, 1'b1);

        // Reset mid-sequence, then a normal load
        step(1'b1, 2'b11, 8'h5A, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("mid_q",     q,     8'hAF);
        chk("mid_shcnt", shcnt, 4'd4);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_q",     q,     8'h00);
        chk("mid_rst_shcnt", shcnt, 4'd0);
        chk("mid_rst_done",  done,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 2'b11, 8'h33, 1'b0, 1'b0, 1'b0);
        chk("post_rst_load_q",     q,     8'h33);
        chk("post_rst_load_shcnt", shcnt, 4'd0);
        step(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("post_rst_shr_q",     q,     8'h19);
        chk("post_rst_shr_shcnt", shcnt, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

`default_nettype wire
